vga_box_renderer: RTL and testbench



---
 rtl/vga_box_renderer.sv | 74 +++++++
 tb/tb_vga_box_renderer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_box_renderer.sv
// vga_box_renderer: VGA timing, sync generation and per-pixel box/background colour with a per-frame position latch
module vga_box_renderer #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int BOX_W = 20,
  parameter int BOX_H = 20,
  parameter logic [11:0] BOX_RGB = 12'hF00,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        video_on,
  output logic        frame_start
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic [10:0] hcount, vcount, bx, by;
  logic tick, h_last, v_last, vis, in_box, latch, hs_n, vs_n;
  always_comb begin
    tick = div == DW'(CLK_DIV - 1);
    h_last = hcount == 11'(H_TOTAL - 1);
    v_last = vcount == 11'(V_TOTAL - 1);
    vis = hcount < 11'(H_VIS) && vcount < 11'(V_VIS);
    // 12-bit compare so a box near 2047 cannot wrap back into view
    in_box = {1'b0, hcount} >= {1'b0, bx} && {1'b0, hcount} < {1'b0, bx} + 12'(BOX_W) &&
             {1'b0, vcount} >= {1'b0, by} && {1'b0, vcount} < {1'b0, by} + 12'(BOX_H);
    latch = tick && hcount == '0 && vcount == 11'(V_VIS);
    hs_n = !(hcount >= 11'(H_VIS + H_FP) && hcount < 11'(H_VIS + H_FP + H_SYNC));
    vs_n = !(vcount >= 11'(V_VIS + V_FP) && vcount < 11'(V_VIS + V_FP + V_SYNC));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      hcount <= '0;
      vcount <= '0;
      bx <= '0;
      by <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb <= '0;
      video_on <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      frame_start <= latch;
      if (latch) begin
        bx <= x;
        by <= y;
      end
      if (tick) begin
        hcount <= h_last ? '0 : hcount + 1'b1;
        if (h_last) vcount <= v_last ? '0 : vcount + 1'b1;
        hsync <= hs_n;
        vsync <= vs_n;
        video_on <= vis;
        rgb <= !vis ? '0 : in_box ? BOX_RGB : BG_RGB;
      end
    end
  end
endmodule

// File: tb/tb_vga_box_renderer.sv
// tb_vga_box_renderer: directed vectors on a shrunken raster (56x37 ticks) for CLK_DIV=2, plus a CLK_DIV=1 instance
module tb_vga_box_renderer;
  localparam int HV = 40, HF = 4, HS = 6, HB = 6, VV = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  typedef struct {
    int f, h, v;
    logic [10:0] x, y;
    logic [11:0] rgb;
    logic hs, vs, von;
  } vec_t;

  logic clk = 0, rst = 1;
  logic [10:0] x = 0, y = 0;
  logic hsync, vsync, video_on, frame_start;
  logic hsync1, vsync1, video_on1, frame_start1;
  logic [11:0] rgb, rgb1;
  int edges = 0, nvec = 0, nfail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  vga_box_renderer #(.CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BOX_W(5), .BOX_H(4),
    .BOX_RGB(12'hF00), .BG_RGB(12'h00A)) u_dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .video_on(video_on), .frame_start(frame_start));

  vga_box_renderer #(.CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BOX_W(5), .BOX_H(4),
    .BOX_RGB(12'hF00), .BG_RGB(12'h00A)) u_div1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .hsync(hsync1), .vsync(vsync1),
    .rgb(rgb1), .video_on(video_on1), .frame_start(frame_start1));

  function automatic vec_t mk(int f, int h, int v, int xi, int yi, logic [11:0] c,
                              logic hs, logic vs, logic von);
    vec_t r;
    r.f = f; r.h = h; r.v = v; r.x = 11'(xi); r.y = 11'(yi);
    r.rgb = c; r.hs = hs; r.vs = vs; r.von = von;
    return r;
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic go(int e);
    while (edges < e) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
  endtask

  function automatic int pix_edge(int f, int h, int v);
    return 2 * (f * FR + v * HT + h) + 2;
  endfunction

  initial begin
    tbl.push_back(mk(0, 0, 0, 10, 5, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(0, 5, 0, 10, 5, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(0, 40, 0, 10, 5, 12'h000, 1, 1, 0));
    tbl.push_back(mk(0, 43, 0, 10, 5, 12'h000, 1, 1, 0));
    tbl.push_back(mk(0, 44, 0, 10, 5, 12'h000, 0, 1, 0));
    tbl.push_back(mk(0, 49, 0, 10, 5, 12'h000, 0, 1, 0));
    tbl.push_back(mk(0, 50, 0, 10, 5, 12'h000, 1, 1, 0));
    tbl.push_back(mk(0, 4, 3, 10, 5, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(0, 0, 4, 10, 5, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(0, 55, 31, 10, 5, 12'h000, 1, 1, 0));
    tbl.push_back(mk(0, 0, 32, 10, 5, 12'h000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 33, 10, 5, 12'h000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 34, 10, 5, 12'h000, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 10, 5, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(1, 12, 4, 10, 5, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(1, 9, 5, 10, 5, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(1, 10, 5, 10, 5, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(1, 14, 5, 10, 5, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(1, 15, 5, 10, 5, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(1, 12, 8, 25, 5, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(1, 12, 9, 25, 5, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(2, 12, 5, 25, 5, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(2, 25, 5, 25, 5, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(2, 29, 8, 25, 5, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(2, 30, 8, 38, 28, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(3, 37, 28, 38, 28, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(3, 38, 28, 38, 28, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(3, 40, 28, 38, 28, 12'h000, 1, 1, 0));
    tbl.push_back(mk(3, 39, 29, 38, 28, 12'hF00, 1, 1, 1));
    tbl.push_back(mk(3, 39, 30, 2045, 0, 12'h000, 1, 1, 0));
    tbl.push_back(mk(4, 0, 0, 2045, 0, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(4, 1, 0, 2045, 0, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(4, 4, 3, 0, 2046, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(5, 0, 0, 0, 2046, 12'h00A, 1, 1, 1));
    tbl.push_back(mk(5, 0, 1, 0, 2046, 12'h00A, 1, 1, 1));

    x = 10; y = 5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", {rgb, hsync, vsync, video_on, frame_start}, {12'h000, 4'b1100});
    rst = 0;
    edges = 0;
    go(1);
    check("no tick yet", {rgb, hsync, vsync, video_on, frame_start}, {12'h000, 4'b1100});

    foreach (tbl[i]) begin
      x = tbl[i].x;
      y = tbl[i].y;
      go(pix_edge(tbl[i].f, tbl[i].h, tbl[i].v));
      check($sformatf("vec%0d f%0d (%0d,%0d)", i, tbl[i].f, tbl[i].h, tbl[i].v),
            {1'b0, rgb, hsync, vsync, video_on},
            {1'b0, tbl[i].rgb, tbl[i].hs, tbl[i].vs, tbl[i].von});
    end

    // mid-frame reset while both syncs are low
    go(pix_edge(5, 44, 32));
    check("pre-reset syncs", {1'b0, rgb, hsync, vsync, video_on}, {1'b0, 12'h000, 3'b000});
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("mid reset", {rgb, hsync, vsync, video_on, frame_start}, {12'h000, 4'b1100});
    check("mid reset div1", {rgb1, hsync1, vsync1, video_on1, frame_start1}, {12'h000, 4'b1100});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    edges = 0;
    x = 3; y = 2;

    go(1);
    check("div2 edge1", {1'b0, rgb, video_on, frame_start}, {1'b0, 12'h000, 2'b00});
    check("div1 pixel0 box at origin", {1'b0, rgb1, video_on1, frame_start1}, {1'b0, 12'hF00, 2'b10});
    go(2);
    check("div2 pixel0 box at origin", {1'b0, rgb, video_on, hsync}, {1'b0, 12'hF00, 2'b11});
    go(44);
    check("div1 hsync pix43", {15'b0, hsync1}, 16'h1);
    go(45);
    check("div1 hsync pix44", {15'b0, hsync1}, 16'h0);
    go(50);
    check("div1 hsync pix49", {15'b0, hsync1}, 16'h0);
    go(51);
    check("div1 hsync pix50", {15'b0, hsync1}, 16'h1);
    go(VV * HT);
    check("div1 fs before", {15'b0, frame_start1}, 16'h0);
    go(VV * HT + 1);
    check("div1 fs pulse", {15'b0, frame_start1}, 16'h1);
    go(VV * HT + 2);
    check("div1 fs after", {15'b0, frame_start1}, 16'h0);
    go(2 * VV * HT + 1);
    check("div2 fs before", {15'b0, frame_start}, 16'h0);
    go(2 * VV * HT + 2);
    check("div2 fs pulse", {15'b0, frame_start}, 16'h1);
    go(2 * VV * HT + 3);
    check("div2 fs after", {15'b0, frame_start}, 16'h0);
    go(VV * HT + 1 + FR);
    check("div1 fs next frame", {15'b0, frame_start1}, 16'h1);
    go(pix_edge(1, 3, 2));
    check("div2 new box (3,2)", {1'b0, rgb, hsync, vsync, video_on}, {1'b0, 12'hF00, 3'b111});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
